// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB slave controller that turns single AHB transfers into APB setup/enable cycles.
// Optional APB3 wait/error handshake (PREADY, PSLVERR) is enabled by defining APB3_PREADY_EN.
module ahb_apb_bridge_ctrl #(
  parameter int          NSLV      = 4,
  parameter int          SLV_SHIFT = 24,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic            clock,
  input  logic            HRESET,
  input  logic            HSELAPB,
  input  logic [31:0]     HADDR,
  input  logic [1:0]      HTRANS,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [31:0]     HWDATA,
  input  logic            HREADYin,
  output logic            HREADYout,
  output logic [1:0]      HRESP,
  output logic [31:0]     HRDATA,
  output logic [31:0]     PADDR,
  output logic [31:0]     PWDATA,
  output logic            PWRITE,
  output logic [NSLV-1:0] PSEL,
  output logic            PENABLE,
`ifdef APB3_PREADY_EN
  input  logic            PREADY,
  input  logic            PSLVERR,
`endif
  input  logic [31:0]     PRDATA
);

  localparam int IW  = $clog2(NSLV);
  localparam int TOP = SLV_SHIFT + IW;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_SETUP = 3'd1,
    ST_RD_EN    = 3'd2,
    ST_WR_WAIT  = 3'd3,
    ST_WR_SETUP = 3'd4,
    ST_WR_EN    = 3'd5,
    ST_ERR1     = 3'd6,
    ST_ERR2     = 3'd7
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  state_t          acc_nxt_s;
  logic            pready_s;
  logic            pslverr_s;
  logic            ok_s;
  logic            valid_s;
  logic            mapped_s;
  logic            accept_s;
  logic            hready_s;
  logic [1:0]      hresp_s;
  logic [IW-1:0]   idx_nxt_s;
  logic [NSLV-1:0] psel_nxt_s;
  logic            penable_nxt_s;
  logic            pwrite_nxt_s;
  logic            unused_s;

  function automatic logic [NSLV-1:0] onehot(input logic [IW-1:0] i);
    logic [NSLV-1:0] v;
    v    = {NSLV{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

`ifdef APB3_PREADY_EN
  assign pready_s  = PREADY;
  assign pslverr_s = PSLVERR;
`else
  assign pready_s  = 1'b1;
  assign pslverr_s = 1'b0;
`endif

  // A completing enable phase only looks OKAY to AHB when the slave reported no error.
  assign ok_s      = pready_s & ~pslverr_s;
  assign valid_s   = HSELAPB & HREADYin & HTRANS[1];
  assign mapped_s  = (HADDR[31:TOP] == BASE_ADDR[31:TOP]);
  assign acc_nxt_s = !valid_s ? ST_IDLE :
                     (!mapped_s ? ST_ERR1 : (HWRITE ? ST_WR_WAIT : ST_RD_SETUP));
  assign idx_nxt_s = accept_s ? HADDR[SLV_SHIFT +: IW] : PADDR[SLV_SHIFT +: IW];
  assign unused_s  = ^{HSIZE, HTRANS[0]};

  // Next-state decode and AHB response generation
  always_comb begin
    state_nxt_s = state_r;
    hready_s    = 1'b1;
    hresp_s     = 2'b00;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        accept_s    = 1'b1;
        state_nxt_s = acc_nxt_s;
      end
      ST_RD_SETUP: begin
        hready_s    = 1'b0;
        state_nxt_s = ST_RD_EN;
      end
      ST_WR_WAIT: begin
        hready_s    = 1'b0;
        state_nxt_s = ST_WR_SETUP;
      end
      ST_WR_SETUP: begin
        hready_s    = 1'b0;
        state_nxt_s = ST_WR_EN;
      end
      ST_RD_EN, ST_WR_EN: begin
        hready_s = ok_s;
        if (!pready_s) begin
          state_nxt_s = state_r;
        end else if (pslverr_s) begin
          state_nxt_s = ST_ERR1;
        end else begin
          accept_s    = 1'b1;
          state_nxt_s = acc_nxt_s;
        end
      end
      ST_ERR1: begin
        hready_s    = 1'b0;
        hresp_s     = 2'b01;
        state_nxt_s = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_s     = 2'b01;
        accept_s    = 1'b1;
        state_nxt_s = acc_nxt_s;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // APB control values for the state being entered
  always_comb begin
    psel_nxt_s    = {NSLV{1'b0}};
    penable_nxt_s = 1'b0;
    pwrite_nxt_s  = PWRITE;
    case (state_nxt_s)
      ST_RD_SETUP: begin
        psel_nxt_s   = onehot(idx_nxt_s);
        pwrite_nxt_s = 1'b0;
      end
      ST_RD_EN: begin
        psel_nxt_s    = onehot(idx_nxt_s);
        penable_nxt_s = 1'b1;
        pwrite_nxt_s  = 1'b0;
      end
      ST_WR_WAIT: begin
        // keep the select up across back-to-back accesses to the same slave
        psel_nxt_s = (PSEL == onehot(idx_nxt_s)) ? PSEL : {NSLV{1'b0}};
      end
      ST_WR_SETUP: begin
        psel_nxt_s   = onehot(idx_nxt_s);
        pwrite_nxt_s = 1'b1;
      end
      ST_WR_EN: begin
        psel_nxt_s    = onehot(idx_nxt_s);
        penable_nxt_s = 1'b1;
        pwrite_nxt_s  = 1'b1;
      end
      default: begin
        psel_nxt_s = {NSLV{1'b0}};
      end
    endcase
  end

  // State and registered APB outputs
  always_ff @(posedge clock or posedge HRESET) begin
    if (HRESET) begin
      state_r <= ST_IDLE;
      PSEL    <= {NSLV{1'b0}};
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= 32'h0;
      PWDATA  <= 32'h0;
    end else begin
      state_r <= state_nxt_s;
      PSEL    <= psel_nxt_s;
      PENABLE <= penable_nxt_s;
      PWRITE  <= pwrite_nxt_s;
      if (accept_s && valid_s && mapped_s) begin
        PADDR <= HADDR;
      end
      if (state_r == ST_WR_WAIT) begin
        PWDATA <= HWDATA;
      end
    end
  end

  assign HREADYout = hready_s;
  assign HRESP     = hresp_s;
  assign HRDATA    = (state_r == ST_RD_EN && ok_s) ? PRDATA : 32'h0;

endmodule
